// File: rtl/pp_gen_pkg.sv
// Shared types and sizing helpers for the partial product generator.
// Holds the FSM state encoding and the slot counter width function.
package pp_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } pp_state_t;

    // Slot counter width: max(1, clog2(size)).
    function automatic int unsigned cnt_width(input int unsigned size);
        return (size <= 1) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/partial_product_generator.sv
// Sequential partial product generator: one slot per cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_ready accept
// multiplicand (DATA_WIDTH) and multiplier (SIZE); partial_products
// (SIZE*DATA_WIDTH) is presented with out_valid until out_ready.
module partial_product_generator
    import pp_gen_pkg::*;
#(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      multiplicand,
    input  logic [SIZE-1:0]            multiplier,
    output logic [SIZE*DATA_WIDTH-1:0] partial_products,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CW = cnt_width(SIZE);

    pp_state_t                 r_state;
    pp_state_t                 w_state_next;
    logic [CW-1:0]             r_cnt;
    logic [DATA_WIDTH-1:0]     r_mcand;
    logic [SIZE-1:0]           r_mplier;
    logic [SIZE*DATA_WIDTH-1:0] r_pp;
    logic [DATA_WIDTH-1:0]     w_slot;
    logic                      w_last;

    // r_mcand holds multiplicand << k (truncated) and r_mplier[0]
    // holds multiplier[k] while slot k is being written.
    assign w_slot = r_mplier[0] ? r_mcand : '0;
    assign w_last = (r_cnt == CW'(SIZE - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= multiplicand;
                        r_mplier <= multiplier;
                        r_pp     <= '0;
                        r_cnt    <= '0;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < SIZE; i++) begin
                        if (r_cnt == CW'(i)) begin
                            r_pp[i*DATA_WIDTH +: DATA_WIDTH] <= w_slot;
                        end
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready         = (r_state == IDLE);
    assign out_valid        = (r_state == DONE);
    assign partial_products = r_pp;

endmodule

// File: tb/tb_partial_product_generator.sv
// Directed self-checking bench for partial_product_generator.
// Covers SIZE=4/DATA_WIDTH=8 and a SIZE=1/DATA_WIDTH=4 instance.
module tb_partial_product_generator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [3:0]  multiplier;
    logic [31:0] bus;
    logic        out_valid;
    logic        out_ready;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  multiplicand1;
    logic [0:0]  multiplier1;
    logic [3:0]  bus1;
    logic        out_valid1;
    logic        out_ready1;

    int n_checks = 0;
    int n_errors = 0;

    partial_product_generator #(.SIZE(4), .DATA_WIDTH(8)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .multiplicand     (multiplicand),
        .multiplier       (multiplier),
        .partial_products (bus),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    partial_product_generator #(.SIZE(1), .DATA_WIDTH(4)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid1),
        .in_ready         (in_ready1),
        .multiplicand     (multiplicand1),
        .multiplier       (multiplier1),
        .partial_products (bus1),
        .out_valid        (out_valid1),
        .out_ready        (out_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one accept on the SIZE=4 instance; returns at the negedge
    // after the accepting edge with in_valid dropped.
    task automatic accept(input logic [7:0] a, input logic [3:0] b);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Edges after the accept until out_valid reads 1 (0 = timeout).
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_out1(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid1) begin
                lat = i;
                break;
            end
        end
    endtask

    logic [7:0]  ta [3];
    logic [3:0]  tb [3];
    logic [31:0] texp [3];

    initial begin
        int lat;
        logic [7:0] sum;

        rst = 1'b1;
        in_valid = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        multiplicand1 = '0;
        multiplier1 = '0;
        out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bus", bus, 0);
        chk("rst_in_ready1", in_ready1, 1);
        chk("rst_bus1", bus1, 0);
        rst = 1'b0;

        // Basic product, latency and adder-tree sum
        accept(8'h0B, 4'b1010);
        chk("t1_busy_in_ready", in_ready, 0);
        chk("t1_busy_out_valid", out_valid, 0);
        wait_out(lat);
        chk("t1_latency", lat, 4);
        chk("t1_bus", bus, 32'h5800_1600);
        sum = bus[7:0] + bus[15:8] + bus[23:16] + bus[31:24];
        chk("t1_sum", sum, 8'h6E);
        @(posedge clk);
        @(negedge clk);
        chk("t1_idle_in_ready", in_ready, 1);
        chk("t1_idle_out_valid", out_valid, 0);

        // Truncation of shifted-out bits
        accept(8'hFF, 4'b1111);
        wait_out(lat);
        chk("t2_latency", lat, 4);
        chk("t2_bus", bus, 32'hF8FC_FEFF);
        @(posedge clk);
        @(negedge clk);

        // Backpressure in DONE with new operands presented
        out_ready = 1'b0;
        accept(8'h05, 4'b0011);
        wait_out(lat);
        chk("t3_latency", lat, 4);
        in_valid = 1'b1;
        multiplicand = 8'h77;
        multiplier = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_in_ready", in_ready, 0);
            chk("t3_hold_bus", bus, 32'h0000_0A05);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_idle_in_ready", in_ready, 1);
        chk("t3_idle_out_valid", out_valid, 0);
        chk("t3_idle_bus", bus, 32'h0000_0A05);

        // Reset on the second BUSY edge
        accept(8'h0B, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t4_in_ready", in_ready, 1);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_bus", bus, 0);
        accept(8'h03, 4'b0001);
        wait_out(lat);
        chk("t4_latency", lat, 4);
        chk("t4_bus_after", bus, 32'h0000_0003);
        @(posedge clk);
        @(negedge clk);

        // SIZE=1 instance
        multiplicand1 = 4'h9;
        multiplier1 = 1'b1;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        chk("s1_busy_out_valid", out_valid1, 0);
        wait_out1(lat);
        chk("s1_latency", lat, 1);
        chk("s1_bus", bus1, 4'h9);
        @(posedge clk);
        @(negedge clk);
        chk("s1_idle_in_ready", in_ready1, 1);
        multiplicand1 = 4'hA;
        multiplier1 = 1'b0;
        in_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        wait_out1(lat);
        chk("s1_zero_bus", bus1, 4'h0);

        // Back-to-back with in_valid held high
        ta[0] = 8'h0B; tb[0] = 4'b1010; texp[0] = 32'h5800_1600;
        ta[1] = 8'h81; tb[1] = 4'b0101; texp[1] = 32'h0004_0081;
        ta[2] = 8'h3C; tb[2] = 4'b1000; texp[2] = 32'hE000_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            multiplicand = ta[k];
            multiplier = tb[k];
            chk("b2b_in_ready", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            chk("b2b_busy", in_ready, 0);
            multiplicand = 8'hC3;
            multiplier = 4'b0110;
            wait_out(lat);
            chk("b2b_latency", lat, 4);
            chk("b2b_bus", bus, {32'h0, texp[k]});
            @(posedge clk);
            @(negedge clk);
            chk("b2b_idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/partial_product_generator.md
PARTIAL_PRODUCT_GENERATOR -- requirements
Module: partial_product_generator

Interface
REQ-001 The block SHALL have parameter SIZE, default 5: number of multiplier bits, equal to the number of partial products; legal range >= 1.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 4: width of the multiplicand and of each partial product.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 The block SHALL have port multiplicand, input, DATA_WIDTH bits: unsigned operand A.
REQ-008 The block SHALL have port multiplier, input, SIZE bits: unsigned operand B.
REQ-009 The block SHALL have port partial_products, output, SIZE*DATA_WIDTH bits: packed bus; slot i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-010 The block SHALL have port out_valid, output, 1 bit: partial_products complete.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer (adder tree stage) takes the bus.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-014 Accept occurs on an edge where state is IDLE and in_valid is 1. On accept, the block SHALL:
- register multiplicand and multiplier;
- clear partial_products to 0;
- clear the slot counter to 0;
- go to BUSY.
REQ-015 On each BUSY edge the block SHALL write slot k (k = counter) = multiplier[k] ? (multiplicand << k) mod 2^DATA_WIDTH : 0, then increment k; exactly one slot is written per cycle.
REQ-016 On the BUSY edge that writes slot SIZE-1, the block SHALL go to DONE; out_valid first reads 1 exactly SIZE cycles after the accepting edge.
REQ-017 In DONE, partial_products SHALL be held stable until the handshake (out_valid and out_ready both 1 on an edge), after which the state SHALL be IDLE.
REQ-018 in_valid in BUSY or DONE SHALL be ignored; no operand capture and no state change. No same-cycle accept on the handshake edge.
REQ-019 Bits shifted beyond DATA_WIDTH SHALL be discarded (modulo arithmetic, matching the adder tree's truncated sum); no carry or overflow output.
REQ-020 With SIZE = 1, the block SHALL reach DONE one cycle after accept, with slot 0 = multiplier[0] ? multiplicand : 0.
REQ-021 Operand inputs SHALL NOT be sampled outside the accept edge; input changes during BUSY SHALL have no effect.

Reset
REQ-022 While rst is 1 on a clk edge, the block SHALL set:
- state = IDLE;
- counter = 0;
- operand registers = 0;
- partial_products = 0.
REQ-023 Reset SHALL take priority over every other event, including reset during BUSY, reset in DONE, and reset coinciding with accept or handshake; the in-flight operation is discarded.
REQ-024 After reset the outputs SHALL read in_ready = 1, out_valid = 0, partial_products = 0.

Structure
REQ-025 A shared package pp_gen_pkg SHALL hold the FSM state typedef (IDLE, BUSY, DONE).
REQ-026 The package SHALL hold a constant or function giving the counter width, max(1, $clog2(SIZE)).
REQ-027 The block SHALL NOT instantiate a sub-module; the slot write is a single shift-and-mask datapath.
REQ-028 A shift register for the multiplicand (left by 1 per cycle) and for the multiplier (right by 1 per cycle) is permitted as the datapath, provided REQ-015 holds.

Verification (SIZE=4, DATA_WIDTH=8 unless stated)
REQ-029 Stimulus: accept A=0x0B, B=4'b1010, out_ready=1. Required: out_valid rises 4 cycles after accept, bus = 0x58001600; bus summed through the adder tree gives 0x6E.
REQ-030 Stimulus: accept A=0xFF, B=4'b1111. Required: bus = 0xF8FCFEFF (truncation check).
REQ-031 Stimulus: out_ready held 0 for 5 cycles in DONE, with in_valid=1 and new operands presented. Required: bus and out_valid stable; in_ready=0; no capture; IDLE one edge after out_ready=1.
REQ-032 Stimulus: rst asserted on the 2nd BUSY edge. Required: next cycle in_ready=1, out_valid=0, bus=0; a following accept of A=0x03, B=4'b0001 yields bus = 0x00000003.
REQ-033 Stimulus: SIZE=1, DATA_WIDTH=4, accept A=0x9, B=1'b1. Required: out_valid 1 cycle after accept, bus = 0x9.
REQ-034 Stimulus: back-to-back operations with in_valid held at 1. Required: each accept is followed by exactly 4 BUSY cycles plus a DONE of at least 1 cycle; no operation lost or duplicated.
